// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: opcodes, select codes and FSM states shared by the multi-cycle RV32I control unit
package rv_ctrl_pkg;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;
    localparam logic [2:0] ALU_XOR  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;
    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_4     = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MDR    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_EXEC_R,
        S_EXEC_I, S_ALU_WB, S_BRANCH, S_JUMP, S_JALR_ADR, S_LUI, S_TRAP
    } state_t;

    typedef enum logic [1:0] {AC_ADD, AC_SUB, AC_R, AC_I} alu_class_t;
endpackage

// File: rtl/rv_multicycle_controller_if.sv
// rv_multicycle_controller_if: instruction/status inputs and datapath control outputs of the controller
interface rv_multicycle_controller_if #(parameter int ALU_FUNC_W = 3);
    logic [6:0]            op;
    logic [2:0]            func3;
    logic [6:0]            func7;
    logic                  zero, neg, mem_ready;
    logic                  PC_write, adr_src, IR_write, mem_write, reg_write;
    logic [1:0]            ALU_src_A, ALU_src_B, result_src;
    logic [2:0]            imm_src;
    logic [ALU_FUNC_W-1:0] ALU_func;
    logic                  illegal, retire;

    modport master (
        input  op, func3, func7, zero, neg, mem_ready,
        output PC_write, adr_src, IR_write, mem_write, reg_write, ALU_src_A, ALU_src_B,
               result_src, imm_src, ALU_func, illegal, retire
    );
    modport slave (
        output op, func3, func7, zero, neg, mem_ready,
        input  PC_write, adr_src, IR_write, mem_write, reg_write, ALU_src_A, ALU_src_B,
               result_src, imm_src, ALU_func, illegal, retire
    );
endinterface

// File: rtl/rv_alu_decoder.sv
// rv_alu_decoder: maps ALU operation class plus func3/func7 to the ALU function code
module rv_alu_decoder
    import rv_ctrl_pkg::*;
#(
    parameter int ALU_FUNC_W = 3
) (
    input  alu_class_t            i_class,
    input  logic [2:0]            i_func3,
    input  logic [6:0]            i_func7,
    output logic [ALU_FUNC_W-1:0] o_alu_func
);
    logic [2:0] w_f3_func;
    logic [2:0] w_func;

    always_comb begin
        w_f3_func = i_func3 == 3'b111 ? ALU_AND  :
                    i_func3 == 3'b110 ? ALU_OR   :
                    i_func3 == 3'b010 ? ALU_SLT  :
                    i_func3 == 3'b100 ? ALU_XOR  :
                    i_func3 == 3'b011 ? ALU_SLTU :
                    (i_func3 == 3'b000 && i_class == AC_R && i_func7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
        w_func    = i_class == AC_SUB ? ALU_SUB : i_class == AC_ADD ? ALU_ADD : w_f3_func;
    end

    assign o_alu_func = ALU_FUNC_W'(w_func);
endmodule

// File: rtl/rv_multicycle_controller.sv
// rv_multicycle_controller: Moore FSM sequencing fetch/decode/execute/memory/writeback for a multi-cycle RV32I core
module rv_multicycle_controller
    import rv_ctrl_pkg::*;
#(
    parameter bit EN_SIGNED_BR = 1'b1,
    parameter bit EN_TRAP      = 1'b1,
    parameter int ALU_FUNC_W   = 3
) (
    input logic clk,
    input logic rst,
    rv_multicycle_controller_if.master bus
);
    state_t     r_state, w_next;
    alu_class_t w_class;
    logic       w_pc_write, w_ir_write, w_mem_write, w_reg_write, w_retire;
    logic       w_br_ok, w_br_take;

    always_ff @(posedge clk) r_state <= rst ? S_FETCH : w_next;

    // beq/bne test zero, blt/bge test neg; func3[0] inverts the condition
    assign w_br_ok   = bus.func3[2:1] == 2'b00 || (EN_SIGNED_BR && bus.func3[2:1] == 2'b10);
    assign w_br_take = (bus.func3[2] ? bus.neg : bus.zero) ^ bus.func3[0];

    always_comb begin
        w_next         = r_state;
        w_pc_write     = 1'b0;
        w_ir_write     = 1'b0;
        w_mem_write    = 1'b0;
        w_reg_write    = 1'b0;
        w_retire       = 1'b0;
        w_class        = AC_ADD;
        bus.adr_src    = 1'b0;
        bus.ALU_src_A  = SRCA_PC;
        bus.ALU_src_B  = SRCB_B;
        bus.imm_src    = IMM_I;
        bus.result_src = RES_ALUOUT;
        case (r_state)
            S_FETCH: begin
                bus.ALU_src_B  = SRCB_4;
                bus.result_src = RES_ALU;
                w_pc_write     = bus.mem_ready;
                w_ir_write     = bus.mem_ready;
                w_next         = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                bus.ALU_src_A = SRCA_OLDPC;
                bus.ALU_src_B = SRCB_IMM;
                bus.imm_src   = bus.op == OP_JAL ? IMM_J : IMM_B;
                case (bus.op)
                    OP_LOAD, OP_STORE: w_next = S_MEM_ADR;
                    OP_R:              w_next = S_EXEC_R;
                    OP_I:              w_next = S_EXEC_I;
                    OP_BR:             w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JUMP;
                    OP_JALR:           w_next = S_JALR_ADR;
                    OP_LUI:            w_next = S_LUI;
                    default: begin
                        w_next   = EN_TRAP ? S_TRAP : S_FETCH;
                        w_retire = !EN_TRAP;
                    end
                endcase
            end
            S_MEM_ADR: begin
                bus.ALU_src_A = SRCA_A;
                bus.ALU_src_B = SRCB_IMM;
                bus.imm_src   = bus.op == OP_STORE ? IMM_S : IMM_I;
                w_next        = bus.op == OP_STORE ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                bus.adr_src = 1'b1;
                w_next      = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                bus.result_src = RES_MDR;
                w_reg_write    = 1'b1;
                w_retire       = 1'b1;
                w_next         = S_FETCH;
            end
            S_MEM_WRITE: begin
                bus.adr_src = 1'b1;
                w_mem_write = 1'b1;
                w_retire    = bus.mem_ready;
                w_next      = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
            end
            S_EXEC_R: begin
                bus.ALU_src_A = SRCA_A;
                w_class       = AC_R;
                w_next        = S_ALU_WB;
            end
            S_EXEC_I: begin
                bus.ALU_src_A = SRCA_A;
                bus.ALU_src_B = SRCB_IMM;
                w_class       = AC_I;
                w_next        = S_ALU_WB;
            end
            S_ALU_WB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                bus.ALU_src_A = SRCA_A;
                w_class       = AC_SUB;
                w_pc_write    = w_br_ok && w_br_take;
                w_retire      = w_br_ok;
                w_next        = w_br_ok ? S_FETCH : S_TRAP;
            end
            S_JALR_ADR: begin
                bus.ALU_src_A = SRCA_A;
                bus.ALU_src_B = SRCB_IMM;
                w_next        = S_JUMP;
            end
            S_JUMP: begin
                bus.ALU_src_A = SRCA_OLDPC;
                bus.ALU_src_B = SRCB_4;
                w_pc_write    = 1'b1;
                w_next        = S_ALU_WB;
            end
            S_LUI: begin
                bus.imm_src    = IMM_U;
                bus.result_src = RES_IMM;
                w_reg_write    = 1'b1;
                w_retire       = 1'b1;
                w_next         = S_FETCH;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
    end

    rv_alu_decoder #(.ALU_FUNC_W(ALU_FUNC_W)) u_alu_dec (
        .i_class   (w_class),
        .i_func3   (bus.func3),
        .i_func7   (bus.func7),
        .o_alu_func(bus.ALU_func)
    );

    // TRAP is left only through reset, so the flag is sticky by construction
    assign bus.illegal   = r_state == S_TRAP;
    assign bus.PC_write  = w_pc_write & ~rst;
    assign bus.IR_write  = w_ir_write & ~rst;
    assign bus.mem_write = w_mem_write & ~rst;
    assign bus.reg_write = w_reg_write & ~rst;
    assign bus.retire    = w_retire & ~rst;
endmodule

// File: tb/tb_rv_multicycle_controller.sv
// tb_rv_multicycle_controller: directed per-cycle control vectors checked by a scoreboard on two controller variants
module tb_rv_multicycle_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mr = 1'b1, zr = 1'b0, ng = 1'b0;
    logic [31:0] ir = 32'h0;
    int          compared = 0, mismatched = 0;

    string       q_n[$];
    logic [18:0] q_v[$], q_v2[$], q_m[$];

    always #5 clk = ~clk;

    rv_multicycle_controller_if #(.ALU_FUNC_W(3)) bus1 ();
    rv_multicycle_controller_if #(.ALU_FUNC_W(3)) bus2 ();

    assign bus1.op = ir[6:0];   assign bus2.op = ir[6:0];
    assign bus1.func3 = ir[14:12]; assign bus2.func3 = ir[14:12];
    assign bus1.func7 = ir[31:25]; assign bus2.func7 = ir[31:25];
    assign bus1.zero = zr;      assign bus2.zero = zr;
    assign bus1.neg = ng;       assign bus2.neg = ng;
    assign bus1.mem_ready = mr; assign bus2.mem_ready = mr;

    rv_multicycle_controller #(.EN_SIGNED_BR(1'b1), .EN_TRAP(1'b1), .ALU_FUNC_W(3)) dut (
        .clk(clk), .rst(rst), .bus(bus1));
    rv_multicycle_controller #(.EN_SIGNED_BR(1'b1), .EN_TRAP(1'b0), .ALU_FUNC_W(3)) dut_nt (
        .clk(clk), .rst(rst), .bus(bus2));

    // {PC_write, adr_src, IR_write, mem_write, reg_write, srcA, srcB, imm, result, func, illegal, retire}
    function automatic logic [18:0] cv(logic pcw, logic adr, logic irw, logic mw, logic rw,
                                       logic [1:0] a, logic [1:0] b, logic [2:0] imm,
                                       logic [1:0] res, logic [2:0] fn, logic ill, logic ret);
        return {pcw, adr, irw, mw, rw, a, b, imm, res, fn, ill, ret};
    endfunction

    function automatic logic [18:0] F(logic m);
        return cv(m, 0, m, 0, 0, 2'b00, 2'b10, 3'b000, 2'b10, 3'b000, 0, 0);
    endfunction
    function automatic logic [18:0] DEC(logic j);
        return cv(0, 0, 0, 0, 0, 2'b01, 2'b01, j ? 3'b011 : 3'b010, 2'b00, 3'b000, 0, 0);
    endfunction
    function automatic logic [18:0] XR(logic [2:0] fn);
        return cv(0, 0, 0, 0, 0, 2'b10, 2'b00, 3'b000, 2'b00, fn, 0, 0);
    endfunction
    function automatic logic [18:0] XI(logic [2:0] fn);
        return cv(0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, 2'b00, fn, 0, 0);
    endfunction
    function automatic logic [18:0] MA(logic s);
        return cv(0, 0, 0, 0, 0, 2'b10, 2'b01, s ? 3'b001 : 3'b000, 2'b00, 3'b000, 0, 0);
    endfunction
    function automatic logic [18:0] MW(logic m);
        return cv(0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0, m);
    endfunction
    function automatic logic [18:0] BR(logic t);
        return cv(t, 0, 0, 0, 0, 2'b10, 2'b00, 3'b000, 2'b00, 3'b001, 0, 1);
    endfunction

    localparam logic [18:0] WB  = 19'b0_0_0_0_1_00_00_000_00_000_0_1;
    localparam logic [18:0] MRD = 19'b0_1_0_0_0_00_00_000_00_000_0_0;
    localparam logic [18:0] MWB = 19'b0_0_0_0_1_00_00_000_01_000_0_1;
    localparam logic [18:0] JMP = 19'b1_0_0_0_0_01_10_000_00_000_0_0;
    localparam logic [18:0] LU  = 19'b0_0_0_0_1_00_00_100_11_000_0_1;
    localparam logic [18:0] TR  = 19'b0_0_0_0_0_00_00_000_00_000_1_0;
    localparam logic [18:0] BRX = 19'b0_0_0_0_0_10_00_000_00_001_0_0;
    localparam logic [18:0] RM  = 19'b1_0_1_1_1_00_00_000_00_000_0_1;
    localparam logic [18:0] ALL = '1;

    task automatic put(input string n, input logic [18:0] v, input logic [18:0] v2, input logic [18:0] m);
        q_n.push_back(n); q_v.push_back(v); q_v2.push_back(v2); q_m.push_back(m);
        @(posedge clk); #1;
    endtask
    task automatic go(input string n, input logic [18:0] v);
        put(n, v, v, ALL);
    endtask

    function automatic logic [18:0] act(logic sel);
        return sel ? {bus2.PC_write, bus2.adr_src, bus2.IR_write, bus2.mem_write, bus2.reg_write,
                      bus2.ALU_src_A, bus2.ALU_src_B, bus2.imm_src, bus2.result_src, bus2.ALU_func,
                      bus2.illegal, bus2.retire}
                   : {bus1.PC_write, bus1.adr_src, bus1.IR_write, bus1.mem_write, bus1.reg_write,
                      bus1.ALU_src_A, bus1.ALU_src_B, bus1.imm_src, bus1.result_src, bus1.ALU_func,
                      bus1.illegal, bus1.retire};
    endfunction

    always @(negedge clk) begin
        string n;
        logic [18:0] e, e2, m, a1, a2;
        if (q_v.size() != 0) begin
            n = q_n.pop_front(); e = q_v.pop_front(); e2 = q_v2.pop_front(); m = q_m.pop_front();
            a1 = act(1'b0) & m; a2 = act(1'b1) & m;
            compared++;
            if (a1 !== (e & m)) begin
                mismatched++;
                $display("FAIL %s trap_on: got %b want %b", n, a1, e & m);
            end
            compared++;
            if (a2 !== (e2 & m)) begin
                mismatched++;
                $display("FAIL %s trap_off: got %b want %b", n, a2, e2 & m);
            end
        end
    end

    initial begin
        @(posedge clk); #1;
        put("rst_a", 19'd0, 19'd0, RM);
        put("rst_b", 19'd0, 19'd0, RM);
        rst = 1'b0;
        ir = 32'h002081B3;
        go("add_f", F(1)); go("add_d", DEC(0)); go("add_x", XR(3'b000)); go("add_wb", WB);
        ir = 32'h0000A183; mr = 1'b0;
        repeat (3) go("lw_fwait", F(0));
        mr = 1'b1; go("lw_f", F(1)); go("lw_d", DEC(0)); go("lw_ma", MA(0));
        mr = 1'b0; repeat (2) go("lw_rwait", MRD);
        mr = 1'b1; go("lw_r", MRD); go("lw_wb", MWB);
        ir = 32'h402081B3;
        go("sub_f", F(1)); go("sub_d", DEC(0)); go("sub_x", XR(3'b001)); go("sub_wb", WB);
        ir = 32'h0020F1B3;
        go("and_f", F(1)); go("and_d", DEC(0)); go("and_x", XR(3'b010)); go("and_wb", WB);
        ir = 32'h0050C093;
        go("xori_f", F(1)); go("xori_d", DEC(0)); go("xori_x", XI(3'b101)); go("xori_wb", WB);
        ir = 32'h40008093;
        go("addi_f", F(1)); go("addi_d", DEC(0)); go("addi_x", XI(3'b000)); go("addi_wb", WB);
        ir = 32'h0020A223;
        go("sw_f", F(1)); go("sw_d", DEC(0)); go("sw_ma", MA(1));
        mr = 1'b0; go("sw_wait", MW(0));
        mr = 1'b1; go("sw_w", MW(1));
        ir = 32'h00208063; zr = 1'b1; ng = 1'b0;
        go("beq_f", F(1)); go("beq_d", DEC(0)); go("beq_br", BR(1));
        ir = 32'h00209063;
        go("bne_f", F(1)); go("bne_d", DEC(0)); go("bne_br", BR(0));
        ir = 32'h0020C063; zr = 1'b0; ng = 1'b1;
        go("blt_f", F(1)); go("blt_d", DEC(0)); go("blt_br", BR(1));
        ir = 32'h0020D063;
        go("bge_f", F(1)); go("bge_d", DEC(0)); go("bge_br", BR(0));
        ng = 1'b0;
        ir = 32'h008000EF;
        go("jal_f", F(1)); go("jal_d", DEC(1)); go("jal_j", JMP); go("jal_wb", WB);
        ir = 32'h000080E7;
        go("jalr_f", F(1)); go("jalr_d", DEC(0)); go("jalr_a", XI(3'b000)); go("jalr_j", JMP); go("jalr_wb", WB);
        ir = 32'h123450B7;
        go("lui_f", F(1)); go("lui_d", DEC(0)); go("lui_x", LU);
        ir = 32'h0000A183;
        go("rlw_f", F(1)); go("rlw_d", DEC(0)); go("rlw_ma", MA(0));
        mr = 1'b0; go("rlw_r", MRD);
        mr = 1'b1; rst = 1'b1;
        put("mid_rst_a", 19'd0, 19'd0, RM);
        put("mid_rst_b", 19'd0, 19'd0, RM);
        rst = 1'b0;
        go("post_f", F(1)); go("post_d", DEC(0)); go("post_ma", MA(0)); go("post_r", MRD); go("post_wb", MWB);
        ir = 32'h0020A063;
        go("badbr_f", F(1)); go("badbr_d", DEC(0)); go("badbr_br", BRX); go("badbr_trap", TR);
        rst = 1'b1; put("badbr_rst", 19'd0, 19'd0, RM); rst = 1'b0;
        ir = 32'h0000007F;
        go("ill_f", F(1));
        put("ill_d", DEC(0), DEC(0) | 19'd1, ALL);
        put("ill_t1", TR, F(1), ALL);
        put("ill_t2", TR, DEC(0) | 19'd1, ALL);
        put("ill_t3", TR, F(1), ALL);
        rst = 1'b1; put("ill_rst", 19'd0, 19'd0, RM); rst = 1'b0;
        ir = 32'h123450B7;
        go("clr_f", F(1)); go("clr_d", DEC(0)); go("clr_x", LU);
        repeat (2) @(posedge clk);
        compared++;
        if (q_v.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending want 0", q_v.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/rv_multicycle_controller.md
Name: rv_multicycle_controller

Overview:
- Control unit for the next-generation multi-cycle RV32I core; it replaces the single-cycle decoder and sits beside the multi-cycle datapath, which shares one instruction/data memory.
- Moore FSM sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives datapath enables and mux selects.
- New behaviour: a memory-ready handshake (wait states), blt/bge branches, lui, a sticky illegal-opcode trap, and a retire pulse for verification.

Parameters:
- EN_SIGNED_BR, 1, when 1 decode blt/bge (func3 100/101); when 0 they trap as illegal.
- EN_TRAP, 1, when 1 an unknown opcode enters TRAP; when 0 it is treated as a NOP and returns to FETCH.
- ALU_FUNC_W, 3, width of the ALU_func output.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- op  in  7  instruction register bits [6:0].
- func3  in  3  instruction register bits [14:12].
- func7  in  7  instruction register bits [31:25].
- zero  in  1  ALU result == 0.
- neg  in  1  ALU signed-less-than flag (sign of rs1-rs2 with overflow correction).
- mem_ready  in  1  memory access completes this cycle.
- PC_write  out  1  load PC.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALU_out register.
- IR_write  out  1  load IR and old_PC.
- mem_write  out  1  store strobe.
- reg_write  out  1  register file write.
- ALU_src_A  out  2  ALU A select: 00 = PC, 01 = old_PC, 10 = A register.
- ALU_src_B  out  2  ALU B select: 00 = B register, 01 = imm, 10 = constant 4.
- imm_src  out  3  immediate type: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- result_src  out  2  result select: 00 = ALU_out register, 01 = MDR, 10 = ALU result, 11 = imm.
- ALU_func  out  ALU_FUNC_W  operation: 000 add, 001 sub, 010 and, 011 or, 100 slt, 101 xor, 110 sltu.
- illegal  out  1  sticky trap flag.
- retire  out  1  one-cycle pulse on the last cycle of each instruction.

Behaviour:
- Reset: on rst=1 at the clock edge, state <= FETCH and illegal <= 0. While rst=1, every write enable (PC_write, IR_write, mem_write, reg_write) and retire is forced to 0. A reset mid-instruction abandons that instruction; no partial writes follow.
- Default for every output in every state is 0 unless listed below.
- FETCH: adr_src=0, ALU_src_A=00, ALU_src_B=10, ALU_func=add, result_src=10. IR_write=PC_write=mem_ready. Stay in FETCH while mem_ready=0, else go to DECODE.
- DECODE: ALU_src_A=01, ALU_src_B=01, ALU_func=add, so ALU_out = old_PC+imm. imm_src is J for jal, else B.
- DECODE transitions by opcode:
  - 0000011 or 0100011 -> MEM_ADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JUMP
  - 1100111 -> JALR_ADR
  - 0110111 -> LUI
  - anything else -> TRAP (EN_TRAP=1) or FETCH with retire=1 (EN_TRAP=0).
- MEM_ADR: A=10, B=01, add. imm_src is S if op=0100011, else I. Next is MEM_WRITE for a store, MEM_READ for a load.
- MEM_READ: adr_src=1. Hold while mem_ready=0, then go to MEM_WB.
- MEM_WB: result_src=01, reg_write=1, retire=1, then FETCH.
- MEM_WRITE: adr_src=1, mem_write=1. Hold while mem_ready=0. mem_write stays high during the hold. When mem_ready=1: retire=1, then FETCH.
- EXEC_R: A=10, B=00. ALU_func comes from func3/func7: add 000/0000000, sub 000/0100000, and 111, or 110, slt 010, xor 100, sltu 011. Then ALU_WB.
- EXEC_I: A=10, B=01, imm I. ALU_func from func3 only; func3 000 is always add. Then ALU_WB.
- ALU_WB: result_src=00, reg_write=1, retire=1, then FETCH.
- BRANCH: A=10, B=00, sub, result_src=00. PC_write is Mealy: beq=zero, bne=~zero, blt=neg, bge=~neg. retire=1, then FETCH. func3 010/011/110/111 -> TRAP.
- JALR_ADR: A=10, B=01, imm I, add, then JUMP.
- JUMP: PC_write=1 with result_src=00 (target from ALU_out). A=01, B=10, add, so ALU_out <= old_PC+4. Then ALU_WB, which writes the link register.
- LUI: imm_src=100, result_src=11, reg_write=1, retire=1, then FETCH.
- TRAP: illegal=1, no enables asserted, remains in TRAP until rst.
- Cycle counts with mem_ready always 1: R/I-type 4, lw 5, sw 4, branch 3, jal 4, jalr 5, lui 3.

Decomposition:
- Package rv_ctrl_pkg holds: opcode constants, ALU_func codes, imm_src codes, ALU_src_A/ALU_src_B/result_src select codes, and the state enum (14 states, 4-bit encoding).
- One natural sub-module, rv_alu_decoder: combinational mapping of (op class, func3, func7) to ALU_func, instantiated once.

Test Plan:
- rst held 2 cycles mid-MEM_READ, then released -> state FETCH, all enables 0 during reset, first IR_write on the cycle after release with mem_ready=1.
- add x3,x1,x2 (0x002081B3), mem_ready=1 -> IR_write@c0, EXEC_R ALU_func=000@c2, reg_write with result_src=00@c3, retire@c3, FETCH@c4.
- lw (0x0000A183) with mem_ready low for 3 cycles in FETCH and 2 cycles in MEM_READ -> 10 cycles total, IR_write/PC_write only on the ready cycle, reg_write with result_src=01 once.
- Branches:
  - beq with zero=1 -> PC_write=1 in BRANCH;
  - bne with zero=1 -> PC_write=0;
  - blt with neg=1 -> PC_write=1;
  - bge with neg=1 -> PC_write=0.
  Each takes 3 cycles.
- jal (0x008000EF) -> JUMP with PC_write=1 and result_src=00, then ALU_WB with reg_write=1; lui (0x123450B7) -> result_src=11, imm_src=100, 3 cycles.
- op=0x7F with EN_TRAP=1 -> illegal=1 from the cycle after DECODE, no enables thereafter, cleared only by rst; with EN_TRAP=0 -> retire and back to FETCH.
